// File: rtl/accel_defs.sv
// accel_defs: shared widths and writeback FSM state encodings for the convolution accelerator
package accel_defs;
    localparam int DATA_W = 18;
    localparam int ADDR_W = 16;
    localparam int DIM_W  = 8;
    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_RUN  = 2'd1,
        WB_DONE = 2'd2
    } wb_state_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with registered full/empty flags and a synchronous flush
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_n;
    logic do_push, do_pop;
    // Guard push/pop with the registered flags and compute the next occupancy
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        cnt_n = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout = mem[rp];
    end
    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp] <= din;
    end
    // Pointers, occupancy and flags; flush empties the buffer like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt_n;
            full <= cnt_n == (AW+1)'(DEPTH);
            empty <= cnt_n == '0;
        end
    end
endmodule

// File: rtl/result_writeback.sv
// result_writeback: buffers DSP results and writes them in raster order to memory; RESULT_RELU_EN clamps negatives to 0
module result_writeback
    import accel_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W = accel_defs::DATA_W,
    parameter int ADDR_W = accel_defs::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  out_dim,
    input  logic [ADDR_W-1:0] output_memory_offset,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result_data,
    output logic              result_ready,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    input  logic              mem_write_grant,
    output logic              overflow,
    output logic              done
);
    wb_state_t state;
    logic full, empty;
    logic [DATA_W-1:0] head, wdata;
    logic [DIM_W-1:0] dim, x, nx;
    logic [ADDR_W-1:0] off, row_base, nrow;
    logic [16:0] total, wcnt, pcnt;
    logic accept, granted, last, pop, wrap;
    result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(start),
        .push(accept),
        .pop(pop),
        .din(result_data),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    // Handshakes, next raster position after a grant, and the optional ReLU on the FIFO head
    always_comb begin
        total = 17'(dim) * 17'(dim);
        result_ready = state == WB_RUN && !full;
        accept = result_valid && result_ready && pcnt < total;
        granted = mem_write_en && mem_write_grant;
        last = granted && wcnt == total - 17'd1;
        pop = state == WB_RUN && (!mem_write_en || mem_write_grant) && !empty;
        wrap = x == dim - DIM_W'(1);
        nx = granted ? (wrap ? '0 : x + DIM_W'(1)) : x;
        nrow = granted && wrap ? row_base + ADDR_W'(dim) : row_base;
`ifdef RESULT_RELU_EN
        wdata = head[DATA_W-1] ? '0 : head;
`else
        wdata = head;
`endif
    end
    // FSM, counters and the held write request; start restarts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
            dim <= '0;
            off <= '0;
            x <= '0;
            row_base <= '0;
            wcnt <= '0;
            pcnt <= '0;
            mem_write_en <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            state <= WB_RUN;
            dim <= out_dim;
            off <= output_memory_offset;
            x <= '0;
            row_base <= '0;
            wcnt <= '0;
            pcnt <= '0;
            mem_write_en <= 1'b0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else begin
            if (result_valid && !accept) overflow <= 1'b1;
            if (accept) pcnt <= pcnt + 17'd1;
            if (granted) wcnt <= wcnt + 17'd1;
            x <= nx;
            row_base <= nrow;
            if (state == WB_RUN && (total == '0 || last)) begin
                state <= WB_DONE;
                done <= 1'b1;
                mem_write_en <= 1'b0;
            end else if (pop) begin
                mem_write_en <= 1'b1;
                mem_write_addr <= off + nrow + ADDR_W'(nx);
                mem_write_data <= wdata;
            end else if (granted) begin
                mem_write_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed table and sequence bench for result_writeback
module tb_result_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] out_dim = '0;
    logic [15:0] output_memory_offset = '0;
    logic result_valid = 1'b0;
    logic [17:0] result_data = '0;
    logic mem_write_grant = 1'b0;
    logic result_ready, mem_write_en, overflow, done;
    logic [15:0] mem_write_addr;
    logic [17:0] mem_write_data;

    typedef struct {
        logic [7:0] dim;
        logic [15:0] off;
        logic [3:0][17:0] din;
        logic [3:0][15:0] ea;
    } vec_t;

    int pass_n = 0;
    int total_n = 0;
    logic [15:0] la[$];
    logic [17:0] ld[$];
    logic done_last = 1'b0;
    logic pend = 1'b0;
    logic [15:0] pa;
    logic [17:0] pd;

    result_writeback dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .out_dim(out_dim),
        .output_memory_offset(output_memory_offset),
        .result_valid(result_valid),
        .result_data(result_data),
        .result_ready(result_ready),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en),
        .mem_write_grant(mem_write_grant),
        .overflow(overflow),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [17:0] ed(input logic [17:0] d);
`ifdef RESULT_RELU_EN
        return d[17] ? 18'd0 : d;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [17:0] d);
        result_valid = 1'b1;
        result_data = d;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] dim, input logic [15:0] off);
        la.delete();
        ld.delete();
        out_dim = dim;
        output_memory_offset = off;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (la.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("log_timeout", 32'(la.size() >= n), 32'd1);
        chk("log_count", la.size(), n);
    endtask

    // Log every granted write and require a refused write to stay put until granted
    always @(negedge clk) begin
        if (pend) begin
            chk("hold_en", mem_write_en, 1'b1);
            chk("hold_addr", mem_write_addr, pa);
            chk("hold_data", mem_write_data, pd);
        end
        pend = mem_write_en && !mem_write_grant && !start && !rst;
        pa = mem_write_addr;
        pd = mem_write_data;
        if (mem_write_en && mem_write_grant) begin
            la.push_back(mem_write_addr);
            ld.push_back(mem_write_data);
            done_last = done;
        end
    end

    initial begin
        vec_t vecs[3];
        int t2[9];
        int t3[10];
        int n;
        vecs[0] = '{dim: 8'd2, off: 16'h0100,
                    din: {18'd9, 18'd7, 18'h3FFFD, 18'd5},
                    ea: {16'h0103, 16'h0102, 16'h0101, 16'h0100}};
        vecs[1] = '{dim: 8'd2, off: 16'hFFFE,
                    din: {18'h20000, 18'd1, 18'h1FFFF, 18'h3FFFF},
                    ea: {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}};
        vecs[2] = '{dim: 8'd1, off: 16'h0042,
                    din: {18'd0, 18'd0, 18'd0, 18'h00ABC},
                    ea: {16'h0000, 16'h0000, 16'h0000, 16'h0042}};
        t2 = '{10, -20, 30, 40, -50, 60, 70, 80, 90};
        t3 = '{1, 2, -3, 4, 5, 666, 7, -8, 9, 10};

        tick();
        tick();
        chk("rst_en", mem_write_en, 1'b0);
        chk("rst_addr", mem_write_addr, 16'h0);
        chk("rst_data", mem_write_data, 18'h0);
        chk("rst_ready", result_ready, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            n = int'(vecs[i].dim) * int'(vecs[i].dim);
            do_start(vecs[i].dim, vecs[i].off);
            chk("start_ready", result_ready, 1'b1);
            mem_write_grant = 1'b1;
            for (int j = 0; j < n; j++) send(vecs[i].din[j]);
            wait_log(n, 20);
            for (int j = 0; j < n && j < la.size(); j++) begin
                chk("vec_addr", la[j], vecs[i].ea[j]);
                chk("vec_data", ld[j], ed(vecs[i].din[j]));
            end
            chk("vec_done", done, 1'b1);
            chk("vec_done_late", done_last, 1'b0);
            chk("vec_en_off", mem_write_en, 1'b0);
            chk("vec_ready_done", result_ready, 1'b0);
            chk("vec_overflow", overflow, 1'b0);
            tick();
        end

        do_start(8'd3, 16'h0200);
        mem_write_grant = 1'b0;
        for (int k = 0; k < 5; k++) send(18'(t2[k]));
        mem_write_grant = 1'b1;
        tick();
        mem_write_grant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_en", mem_write_en, 1'b1);
            chk("stall_addr", mem_write_addr, 16'h0201);
            chk("stall_data", mem_write_data, ed(18'(t2[1])));
            tick();
        end
        mem_write_grant = 1'b1;
        for (int k = 5; k < 9; k++) send(18'(t2[k]));
        wait_log(9, 40);
        for (int j = 0; j < 9 && j < la.size(); j++) begin
            chk("stall_log_addr", la[j], 16'h0200 + 16'(j));
            chk("stall_log_data", ld[j], ed(18'(t2[j])));
        end
        chk("stall_done", done, 1'b1);
        chk("stall_overflow", overflow, 1'b0);
        tick();

        do_start(8'd3, 16'h0000);
        mem_write_grant = 1'b0;
        for (int k = 0; k < 5; k++) send(18'(t3[k]));
        chk("full_ready", result_ready, 1'b0);
        chk("full_no_ovf", overflow, 1'b0);
        send(18'(t3[5]));
        chk("drop_overflow", overflow, 1'b1);
        chk("drop_head", mem_write_data, ed(18'(t3[0])));
        mem_write_grant = 1'b1;
        tick();
        chk("pop_ready", result_ready, 1'b1);
        for (int k = 6; k < 10; k++) send(18'(t3[k]));
        wait_log(9, 40);
        for (int j = 0; j < 9 && j < la.size(); j++) begin
            chk("drop_log_addr", la[j], 16'(j));
            chk("drop_log_data", ld[j], ed(18'(t3[j < 5 ? j : j + 1])));
        end
        chk("drop_done", done, 1'b1);
        chk("drop_sticky", overflow, 1'b1);
        tick();

        do_start(8'd2, 16'h0300);
        mem_write_grant = 1'b1;
        send(18'd11);
        send(18'd12);
        wait_log(2, 20);
        mem_write_grant = 1'b0;
        send(18'd13);
        send(18'd14);
        send(18'd15);
        chk("pre_restart_ovf", overflow, 1'b1);
        chk("pre_restart_en", mem_write_en, 1'b1);
        chk("pre_restart_addr", mem_write_addr, 16'h0302);
        do_start(8'd2, 16'h0400);
        chk("restart_ovf", overflow, 1'b0);
        chk("restart_en", mem_write_en, 1'b0);
        chk("restart_done", done, 1'b0);
        tick();
        chk("restart_flushed", mem_write_en, 1'b0);
        mem_write_grant = 1'b1;
        for (int k = 0; k < 4; k++) send(18'(21 + k));
        wait_log(4, 20);
        for (int j = 0; j < 4 && j < la.size(); j++) begin
            chk("restart_addr", la[j], 16'h0400 + 16'(j));
            chk("restart_data", ld[j], 18'(21 + j));
        end
        chk("restart_done_end", done, 1'b1);
        chk("restart_done_late", done_last, 1'b0);
        tick();

        do_start(8'd0, 16'h0500);
        chk("zero_done_early", done, 1'b0);
        chk("zero_en0", mem_write_en, 1'b0);
        tick();
        chk("zero_done", done, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("zero_en", mem_write_en, 1'b0);
            tick();
        end

        do_start(8'd2, 16'h0600);
        mem_write_grant = 1'b0;
        send(18'd33);
        tick();
        chk("pend_en", mem_write_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_en", mem_write_en, 1'b0);
        chk("rst_mid_addr", mem_write_addr, 16'h0);
        chk("rst_mid_ready", result_ready, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        tick();

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
